// File: rtl/lamp_guard.sv
// lamp_guard: registered lamp output stage with conflict watchdog, fault
// latch with flashing reds, and a timed lamp-test mode.
module lamp_guard #(
    parameter int unsigned CONFLICT_FILTER   = 2,
    parameter int unsigned LAMP_TEST_SECONDS = 3
) (
    input  logic       clock,
    input  logic       reset_sync,
    input  logic       enable_1Hz,
    input  logic [6:0] led_in,
    input  logic       lamp_test,
    input  logic       fault_clear,
    output logic [6:0] lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_TEST  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [6:0] LAMP_REDS = 7'b1001000;
    localparam logic [6:0] LAMP_ALL  = 7'b1111111;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(CONFLICT_FILTER - 1);
    localparam logic [CNT_W-1:0] TEST_END  = CNT_W'(LAMP_TEST_SECONDS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state, state_nx;
    logic [6:0]       lamp_nx;
    logic             fault_nx;
    logic [2:0]       code_nx;
    logic [CNT_W-1:0] filt_cnt, filt_nx;
    logic [CNT_W-1:0] test_cnt, test_nx;
    logic             flash_phase, flash_nx;
    logic             test_armed, armed_nx;

    logic c0, c1, c2, any_conflict, fault_hit;

    // True when exactly one of three aspect bits is lit.
    function automatic logic one_hot3(input logic [2:0] v);
        return (v[2] ^ v[1] ^ v[0]) & ~(v[2] & v[1] & v[0]);
    endfunction

    // Conflict terms decoded directly from the incoming FSM lamp bus.
    always_comb begin
        c0 = (led_in[5] | led_in[4]) & (led_in[2] | led_in[1]);
        c1 = led_in[0] & ~led_in[6];
        c2 = ~one_hot3(led_in[6:4]) | ~one_hot3(led_in[3:1]);
        any_conflict = c0 | c1 | c2;
        fault_hit = (state != ST_FAULT) && any_conflict && (filt_cnt >= FILT_LAST);
    end

    // Next-state and next-output decode; lamp follows the state being entered.
    always_comb begin
        state_nx = state;
        lamp_nx  = lamp;
        fault_nx = fault;
        code_nx  = fault_code;
        test_nx  = test_cnt;
        flash_nx = flash_phase;
        armed_nx = test_armed | ~lamp_test;
        if (any_conflict) begin
            filt_nx = (filt_cnt == CNT_MAX) ? filt_cnt : filt_cnt + CNT_W'(1);
        end else begin
            filt_nx = '0;
        end

        if (fault_hit) begin
            state_nx = ST_FAULT;
            fault_nx = 1'b1;
            code_nx  = {c2, c1, c0};
            flash_nx = 1'b1;
            lamp_nx  = LAMP_REDS;
        end else begin
            case (state)
                ST_RUN: begin
                    if (lamp_test && test_armed) begin
                        state_nx = ST_TEST;
                        test_nx  = '0;
                        armed_nx = 1'b0;
                        lamp_nx  = LAMP_ALL;
                    end else begin
                        lamp_nx = led_in;
                    end
                end
                ST_TEST: begin
                    lamp_nx = LAMP_ALL;
                    if (enable_1Hz) begin
                        if (test_cnt + CNT_W'(1) >= TEST_END) begin
                            state_nx = ST_RUN;
                            test_nx  = '0;
                            lamp_nx  = led_in;
                        end else begin
                            test_nx = test_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clear && !any_conflict) begin
                        state_nx = ST_RUN;
                        fault_nx = 1'b0;
                        code_nx  = 3'b000;
                        filt_nx  = '0;
                        lamp_nx  = led_in;
                    end else begin
                        flash_nx = enable_1Hz ? ~flash_phase : flash_phase;
                        lamp_nx  = {flash_nx, 2'b00, flash_nx, 3'b000};
                    end
                end
                default: begin
                    state_nx = ST_RUN;
                    lamp_nx  = LAMP_REDS;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state       <= ST_RUN;
            lamp        <= LAMP_REDS;
            fault       <= 1'b0;
            fault_code  <= 3'b000;
            filt_cnt    <= '0;
            test_cnt    <= '0;
            flash_phase <= 1'b1;
            test_armed  <= 1'b1;
        end else begin
            state       <= state_nx;
            lamp        <= lamp_nx;
            fault       <= fault_nx;
            fault_code  <= code_nx;
            filt_cnt    <= filt_nx;
            test_cnt    <= test_nx;
            flash_phase <= flash_nx;
            test_armed  <= armed_nx;
        end
    end

endmodule

// File: doc/lamp_guard.md
Name: lamp_guard

Overview:
- Output stage directly downstream of the light-sequencing FSM; consumes its 7-bit lamp bus and drives the physical lamps.
- Registers the lamps and checks every cycle for conflicting aspects. On a filtered conflict it latches a fault and forces flashing reds until an operator clear.
- Provides a timed lamp-test mode.
- Uses the shared enable_1Hz tick from the divider for all timing.

Parameters:
- CONFLICT_FILTER, 2: consecutive clock cycles a conflict must persist before a fault latches (legal range 1-15).
- LAMP_TEST_SECONDS, 3: number of enable_1Hz pulses for which lamp test lights all lamps (legal range 1-15).

Ports:
- clock  input  1  system clock
- reset_sync  input  1  synchronous, active-high reset
- enable_1Hz  input  1  one-cycle pulse, once per second
- led_in  input  7  FSM lamp bus {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
- lamp_test  input  1  synchronized lamp-test request, level
- fault_clear  input  1  synchronized operator clear, level
- lamp  output  7  registered lamp drive, same bit order as led_in
- fault  output  1  latched fault flag
- fault_code  output  3  latched cause: bit0 = both directions open, bit1 = walk while main not red, bit2 = invalid aspect

Behaviour:
- Reset (reset_sync high at a clock edge; this has priority over everything):
  - state = RUN, lamp = 7'b1001000 (both reds), fault = 0, fault_code = 3'b000.
  - Filter counter = 0, test counter = 0, flash_phase = 1, test_armed = 1.
  - Reset mid-fault or mid-test returns to this state on the same edge.
- Combinational conflict terms on led_in:
  - c0: (main_yellow|main_green) & (side_yellow|side_green).
  - c1: walk & ~main_red.
  - c2: either direction's {red, yellow, green} does not contain exactly one set bit.
  - any = c0|c1|c2.
- Filter counter:
  - Increments on each edge where any = 1 and resets to 0 when any = 0. It saturates and is never reset by state.
  - When any has been 1 on CONFLICT_FILTER consecutive edges, the FSM enters FAULT on that edge.
  - On that edge fault <= 1 and fault_code <= {c2, c1, c0} as sampled on that edge, so simultaneous causes are all recorded.
- States:
  - RUN:
    - lamp <= led_in each edge, giving 1-cycle latency.
    - lamp_test = 1 and test_armed = 1 -> go to TEST with test counter = 0 and test_armed <= 0.
  - TEST:
    - lamp <= 7'b1111111.
    - Test counter increments on each enable_1Hz. When it reaches LAMP_TEST_SECONDS, go to RUN.
    - Conflict detection stays active on led_in.
  - FAULT:
    - lamp <= {flash_phase, 0, 0, flash_phase, 0, 0, 0}.
    - flash_phase is set to 1 on entry and toggles on each enable_1Hz while in FAULT.
    - fault_clear = 1 and any = 0 on the same edge -> go to RUN: fault <= 0, fault_code <= 0, filter counter <= 0, lamp <= led_in.
    - fault_clear while any = 1 is ignored.
- test_armed:
  - Set to 1 on any edge where lamp_test = 0.
  - lamp_test held high permanently therefore gives exactly one test.
- Priorities within one edge: reset > fault entry > fault_clear > lamp-test entry/exit.
  - A fault detected during TEST aborts the test immediately.
  - lamp_test is ignored in FAULT.
- enable_1Hz only affects the test counter and flash_phase; there is no other dependence on it.

Test Plan:
- Reset, then led_in = 7'b0011000 (main green, side red) -> lamp = 7'b0011000 one cycle later; fault = 0.
- led_in = 7'b0010010 (both green) held 2 cycles -> fault = 1, fault_code = 3'b001 after the 2nd edge; lamp = 7'b1001000. After each subsequent enable_1Hz pulse lamp alternates 7'b0000000 / 7'b1001000.
- led_in = 7'b0011000 for 1 cycle only, with walk = 1 for that one cycle -> no fault (filter of 2 not satisfied); lamp follows input.
- led_in = 7'b0000101 (main dark, walk on) for 2 cycles -> fault_code = 3'b110. Assert fault_clear while the conflict persists -> no change. Set led_in = 7'b1001001 and assert fault_clear -> RUN next edge, fault = 0, lamp = 7'b1001001.
- lamp_test held high with valid led_in -> lamp = 7'b1111111 for exactly 3 enable_1Hz pulses, then lamp = led_in. No second test until lamp_test drops and rises again.
- Assert reset_sync during TEST and during FAULT -> next edge: lamp = 7'b1001000, fault = 0, fault_code = 0, state RUN.
